// File: rtl/mem_arbiter_pkg.sv
// rtl/mem_arbiter_pkg.sv - shared LC3 memory-path constants for the arbiter
package mem_arbiter_pkg;

  localparam logic [1:0] ST_IDLE   = 2'b00;
  localparam logic [1:0] ST_ACCESS = 2'b01;
  localparam logic [1:0] ST_DONE   = 2'b10;

  localparam int DEFAULT_MEM_LATENCY = 2;

endpackage

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-requester round-robin arbiter in front of the memory controller
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDRESS_BITS = 16,
  parameter int MEMORY_BITS  = 16,
  parameter int MEM_LATENCY  = DEFAULT_MEM_LATENCY
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    req0,
  input  logic                    req1,
  input  logic                    we0,
  input  logic                    we1,
  input  logic [ADDRESS_BITS-1:0] addr0,
  input  logic [ADDRESS_BITS-1:0] addr1,
  input  logic [MEMORY_BITS-1:0]  wdata0,
  input  logic [MEMORY_BITS-1:0]  wdata1,
  output logic                    done0,
  output logic                    done1,
  output logic [MEMORY_BITS-1:0]  rdata,
  output logic [ADDRESS_BITS-1:0] mem_addr,
  output logic [MEMORY_BITS-1:0]  mem_data_in,
  output logic                    mem_we,
  output logic                    mem_select,
  input  logic [MEMORY_BITS-1:0]  mem_data_out
);

  localparam logic [3:0] LAT_LOAD = 4'(MEM_LATENCY - 1);

  logic [1:0] state;
  logic [3:0] cnt;
  logic       last_grant;
  logic       grant;
  logic       pick;

  // Requester 1 wins when it is alone, or on a tie when 0 was served last.
  always_comb begin
    pick = req1 & (~req0 | ~last_grant);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      last_grant  <= 1'b1;
      grant       <= 1'b0;
      cnt         <= 4'd0;
      done0       <= 1'b0;
      done1       <= 1'b0;
      rdata       <= '0;
      mem_addr    <= '0;
      mem_data_in <= '0;
      mem_we      <= 1'b0;
      mem_select  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          done0 <= 1'b0;
          done1 <= 1'b0;
          if (req0 || req1) begin
            grant       <= pick;
            last_grant  <= pick;
            mem_addr    <= pick ? addr1 : addr0;
            mem_data_in <= pick ? wdata1 : wdata0;
            mem_we      <= pick ? we1 : we0;
            mem_select  <= 1'b1;
            cnt         <= LAT_LOAD;
            state       <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          if (cnt == 4'd0) begin
            if (!mem_we) begin
              rdata <= mem_data_out;
            end
            mem_select <= 1'b0;
            mem_we     <= 1'b0;
            done0      <= ~grant;
            done1      <= grant;
            state      <= ST_DONE;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        ST_DONE: begin
          done0 <= 1'b0;
          done1 <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          done0      <= 1'b0;
          done1      <= 1'b0;
          mem_select <= 1'b0;
          mem_we     <= 1'b0;
          state      <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - scoreboard bench for mem_arbiter
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0, req1, we0, we1;
  logic [15:0] addr0, addr1, wdata0, wdata1;
  logic        done0, done1, mem_we, mem_select;
  logic [15:0] rdata, mem_addr, mem_data_in, mem_data_out;

  logic        b_req0;
  logic [15:0] b_addr0;
  logic        b_done0, b_done1, b_mem_we, b_mem_select;
  logic [15:0] b_rdata, b_mem_addr, b_mem_data_in, b_mem_data_out;

  logic [15:0] mem [0:65535];
  logic        pl_en;
  logic [15:0] pl_addr, pl_data;

  typedef struct {
    bit          who;
    bit          rd;
    logic [15:0] data;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   checks = 0;
  int   failures = 0;
  int   ndone = 0;
  int   b_ndone = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDRESS_BITS(16), .MEMORY_BITS(16), .MEM_LATENCY(2)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .done0(done0), .done1(done1), .rdata(rdata),
    .mem_addr(mem_addr), .mem_data_in(mem_data_in), .mem_we(mem_we),
    .mem_select(mem_select), .mem_data_out(mem_data_out)
  );

  mem_arbiter #(.ADDRESS_BITS(16), .MEMORY_BITS(16), .MEM_LATENCY(1)) dut_l1 (
    .clk(clk), .reset(reset),
    .req0(b_req0), .req1(1'b0), .we0(1'b0), .we1(1'b0),
    .addr0(b_addr0), .addr1(16'h0000), .wdata0(16'h0000), .wdata1(16'h0000),
    .done0(b_done0), .done1(b_done1), .rdata(b_rdata),
    .mem_addr(b_mem_addr), .mem_data_in(b_mem_data_in), .mem_we(b_mem_we),
    .mem_select(b_mem_select), .mem_data_out(b_mem_data_out)
  );

  // Memory controller model for the main instance; preloads share its write port.
  always @(posedge clk) begin
    if (pl_en) mem[pl_addr] <= pl_data;
    else if (mem_select && mem_we) mem[mem_addr] <= mem_data_in;
  end
  assign mem_data_out = mem[mem_addr];
  assign b_mem_data_out = (b_mem_addr == 16'h0000) ? 16'h1111 :
                          (b_mem_addr == 16'h0001) ? 16'h2222 : 16'h0000;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic preload(input logic [15:0] a, input logic [15:0] d);
    @(negedge clk);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  task automatic wait_done();
    bit seen = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (done0 || done1) begin
        seen = 1'b1;
        break;
      end
    end
    check("done_seen", seen, 1);
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (done0 || done1) begin
        ndone++;
        check("done_exclusive", done0 & done1, 0);
        check("done_expected", q.size() > 0, 1);
        if (q.size() > 0) begin
          mon_e = q.pop_front();
          check("done_port", done1, mon_e.who);
          if (mon_e.rd) check("rdata", rdata, mon_e.data);
        end
      end
      if (b_done0) b_ndone++;
      if (b_done1) check("b_done1_never", b_done1, 0);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    int d_before;
    int sel_cycles;
    reset = 1'b1; pl_en = 1'b0; pl_addr = '0; pl_data = '0;
    req0 = 0; req1 = 0; we0 = 0; we1 = 0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    b_req0 = 0; b_addr0 = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_done0", done0, 0);
    check("rst_done1", done1, 0);
    check("rst_rdata", rdata, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_data_in", mem_data_in, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_select", mem_select, 0);
    reset = 1'b0;

    // requester 0 write, latency 2
    @(negedge clk);
    req0 = 1; we0 = 1; addr0 = 16'h3000; wdata0 = 16'h1234;
    q.push_back('{1'b0, 1'b0, 16'h0000});
    @(negedge clk);
    check("wr_sel_c1", mem_select, 1);
    check("wr_we_c1", mem_we, 1);
    check("wr_addr_c1", mem_addr, 16'h3000);
    check("wr_data_c1", mem_data_in, 16'h1234);
    @(negedge clk);
    check("wr_sel_c2", mem_select, 1);
    check("wr_we_c2", mem_we, 1);
    @(negedge clk);
    check("wr_done0_c3", done0, 1);
    check("wr_done1_c3", done1, 0);
    check("wr_sel_c3", mem_select, 0);
    check("wr_we_c3", mem_we, 0);
    req0 = 0; we0 = 0;
    @(negedge clk);
    check("wr_done0_after", done0, 0);
    check("wr_mem_content", mem[16'h3000], 16'h1234);

    // requester 1 read of preloaded word
    preload(16'h3000, 16'hBEEF);
    d_before = ndone;
    @(negedge clk);
    req1 = 1; we1 = 0; addr1 = 16'h3000;
    q.push_back('{1'b1, 1'b1, 16'hBEEF});
    wait_done();
    check("rd_rdata_with_done1", rdata, 16'hBEEF);
    req1 = 0;
    repeat (3) @(negedge clk);
    check("rd_single_done", ndone - d_before, 1);

    // both requesters held from reset: round-robin 0,1,0,1
    @(negedge clk); reset = 1;
    @(negedge clk); reset = 0;
    preload(16'h0010, 16'hA0A0);
    preload(16'h0020, 16'hB1B1);
    d_before = ndone;
    @(negedge clk);
    req0 = 1; we0 = 0; addr0 = 16'h0010;
    req1 = 1; we1 = 0; addr1 = 16'h0020;
    for (int i = 0; i < 4; i++) begin
      q.push_back('{bit'(i % 2), 1'b1, (i % 2) ? 16'hB1B1 : 16'hA0A0});
    end
    for (int i = 0; i < 4; i++) wait_done();
    req0 = 0; req1 = 0;
    repeat (6) @(negedge clk);
    check("rr_done_count", ndone - d_before, 4);
    check("rr_queue_empty", q.size(), 0);

    // reset in first ACCESS cycle of a write aborts it
    @(negedge clk);
    req0 = 1; we0 = 1; addr0 = 16'h4000; wdata0 = 16'h5555;
    @(negedge clk);
    check("abort_sel_before", mem_select, 1);
    reset = 1; req0 = 0; we0 = 0;
    @(negedge clk);
    check("abort_sel", mem_select, 0);
    check("abort_we", mem_we, 0);
    check("abort_addr", mem_addr, 0);
    check("abort_data", mem_data_in, 0);
    check("abort_rdata", rdata, 0);
    check("abort_done", {done1, done0}, 0);
    reset = 0;
    d_before = ndone;
    repeat (4) @(negedge clk);
    check("abort_no_done", ndone - d_before, 0);
    check("abort_idle_sel", mem_select, 0);

    // ungranted requester toggles during an access
    preload(16'h0055, 16'h5A5A);
    @(negedge clk);
    req0 = 1; we0 = 0; addr0 = 16'h0055;
    q.push_back('{1'b0, 1'b1, 16'h5A5A});
    sel_cycles = 0;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      if (mem_select) begin
        sel_cycles++;
        check("iso_mem_addr", mem_addr, 16'h0055);
      end
      if (done0 || done1) begin
        req1 = 0;
        break;
      end
      req1 = ~req1;
      addr1 = 16'($urandom);
    end
    req0 = 0;
    check("iso_sel_cycles", sel_cycles, 2);
    repeat (4) @(negedge clk);

    // latency-1 instance: back-to-back reads of 0x0000 then 0x0001
    @(negedge clk);
    b_req0 = 1; b_addr0 = 16'h0000;
    @(negedge clk);
    check("b2b_sel_1", b_mem_select, 1);
    check("b2b_addr_1", b_mem_addr, 16'h0000);
    @(negedge clk);
    check("b2b_done_1", b_done0, 1);
    check("b2b_rdata_1", b_rdata, 16'h1111);
    check("b2b_sel_done1", b_mem_select, 0);
    b_addr0 = 16'h0001;
    @(negedge clk);
    check("b2b_idle_sel", b_mem_select, 0);
    check("b2b_idle_done", b_done0, 0);
    @(negedge clk);
    check("b2b_sel_2", b_mem_select, 1);
    check("b2b_addr_2", b_mem_addr, 16'h0001);
    @(negedge clk);
    check("b2b_done_2", b_done0, 1);
    check("b2b_rdata_2", b_rdata, 16'h2222);
    b_req0 = 0;
    repeat (4) @(negedge clk);
    check("b2b_done_count", b_ndone, 2);

    check("final_queue_empty", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The module SHALL have parameter ADDRESS_BITS, default 16, width of all address ports.
REQ-002 The module SHALL have parameter MEMORY_BITS, default 16, width of all data ports.
REQ-003 The module SHALL have parameter MEM_LATENCY, default 2, range 1..15: cycles mem_select is held per access.
REQ-004 The module SHALL have port clk  input  1  the single clock; all logic on its rising edge.
REQ-005 The module SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 The module SHALL have ports req0, req1  input  1 each  access request from requester 0 (CPU MAR/MDR path) and requester 1 (debug/loader).
REQ-007 The module SHALL have ports we0, we1  input  1 each  1 = write, 0 = read.
REQ-008 The module SHALL have ports addr0, addr1  input  ADDRESS_BITS each  access address.
REQ-009 The module SHALL have ports wdata0, wdata1  input  MEMORY_BITS each  write data.
REQ-010 The module SHALL have ports done0, done1  output  1 each  one-cycle completion pulse to the granted requester.
REQ-011 The module SHALL have port rdata  output  MEMORY_BITS  read data, valid while done0 or done1 is high.
REQ-012 The module SHALL have ports mem_addr, mem_data_in, mem_we, mem_select  output  ADDRESS_BITS/MEMORY_BITS/1/1  drive to the memory controller.
REQ-013 The module SHALL have port mem_data_out  input  MEMORY_BITS  read data from the memory controller.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, ACCESS and DONE.
REQ-015 In IDLE with no request, the FSM SHALL stay in IDLE with mem_select=0 and mem_we=0.
REQ-016 In IDLE with one request, the FSM SHALL grant that requester and register its we/addr/wdata into the mem_* outputs on the next edge, then enter ACCESS.
REQ-017 In IDLE with both requests, the FSM SHALL grant the requester not granted last (round-robin); after reset, requester 0 wins the first tie.
REQ-018 In ACCESS, mem_select SHALL be 1 and mem_addr/mem_we/mem_data_in SHALL hold the latched values for exactly MEM_LATENCY cycles, counted by a 4-bit down-counter.
REQ-019 On the last ACCESS cycle, the module SHALL register mem_data_out into rdata (reads only; writes leave rdata unchanged), then enter DONE.
REQ-020 In DONE, the module SHALL assert the granted requester's done for exactly one cycle with mem_select=0 and mem_we=0, then return to IDLE.
REQ-021 Latency: a request sampled in IDLE at edge N SHALL give mem_select high for cycles N+1..N+MEM_LATENCY and done high in cycle N+MEM_LATENCY+1.
REQ-022 Requests SHALL be ignored in ACCESS and DONE; a requester SHALL hold req, we, addr and wdata stable until its done, and it may present a new request on the edge that ends DONE (back-to-back).
REQ-023 Changes to an ungranted requester's inputs SHALL have no effect on the access in progress.
REQ-024 done0 and done1 SHALL never be high in the same cycle, and there SHALL be exactly one done per grant.
REQ-025 Address and data SHALL pass through unmodified, with no wrap-around or arithmetic.

Reset
REQ-026 Reset SHALL put the FSM in IDLE, set last-grant to requester 1 (so 0 wins the first tie), clear the counter, and zero done0, done1, rdata, mem_addr, mem_data_in, mem_we and mem_select.
REQ-027 Reset asserted during ACCESS or DONE SHALL abort the access: mem_select=0 from the next cycle and no done issued.
REQ-028 Reset SHALL take priority over every other event in the same cycle.

Structure
REQ-029 The state encoding (IDLE=2'b00, ACCESS=2'b01, DONE=2'b10) and the default MEM_LATENCY SHALL live in the shared LC3 package.
REQ-030 The module SHALL be a single module without sub-modules; round-robin selection SHALL be inline combinational logic.
REQ-031 The module SHALL instantiate between the CPU's MAR/MDR/MEM_EN/MEM_W path and the memory controller, with no change to the memory controller.

Verification
REQ-032 The bench SHALL cover: req0 write addr=16'h3000 data=16'h1234, L=2 -> mem_select high 2 cycles with mem_we=1, done0 in cycle 3, no done1.
REQ-033 The bench SHALL cover: preload 16'h3000=16'hBEEF; req1 read addr=16'h3000 -> done1 pulses once and rdata=16'hBEEF in the same cycle.
REQ-034 The bench SHALL cover: req0 and req1 both held continuously for 4 accesses from reset -> grant order 0,1,0,1; exactly 4 done pulses.
REQ-035 The bench SHALL cover: req0 back-to-back reads of 16'h0000 then 16'h0001 with L=1 -> second mem_select starts 1 cycle after done0; no lost or duplicate access.
REQ-036 The bench SHALL cover: reset pulsed in the 1st ACCESS cycle of a write -> mem_select=0 next cycle, no done, all outputs zero, IDLE.
REQ-037 The bench SHALL cover: during an access by 0, toggle addr1/req1 every cycle -> mem_addr stays at the addr0 value throughout.
